// File: rtl/seq_mem_rf_pkg.sv
// Shared sizing constants and types for the 8x8 zero-register register file.
package seq_mem_rf_pkg;

    localparam int unsigned RF_NUM_ENTRIES = 8;
    localparam int unsigned RF_DATA_WIDTH  = 8;
    localparam int unsigned RF_ADDR_WIDTH  = $clog2(RF_NUM_ENTRIES);

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/seq_mem_rf_wr_decoder.sv
// Turns write_en/write_addr into a one-hot per-entry write strobe; entry 0 is never written.
module seq_mem_rf_wr_decoder
    import seq_mem_rf_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = RF_NUM_ENTRIES,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_ENTRIES)
) (
    input  logic                   write_en_i,
    input  logic [ADDR_WIDTH-1:0]  write_addr_i,
    output logic [NUM_ENTRIES-1:0] entry_we_o
);

    always_comb begin
        entry_we_o = '0;
        if (write_en_i) begin
            entry_we_o[write_addr_i] = 1'b1;
        end
        entry_we_o[0] = 1'b0;
    end

endmodule

// File: rtl/seq_mem_8x8b_1r1w_rf_z.sv
// 8x8 register file, one combinational read and one synchronous write port, entry 0 reads zero.
// Define SEQ_MEM_RF_BYPASS_EN to forward same-cycle write data to a matching read.
module seq_mem_8x8b_1r1w_rf_z
    import seq_mem_rf_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = RF_NUM_ENTRIES,
    parameter int unsigned DATA_WIDTH  = RF_DATA_WIDTH,
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);

    logic [NUM_ENTRIES-1:0] entry_we;
    logic [DATA_WIDTH-1:0]  mem_q [NUM_ENTRIES-1:1];
    logic [DATA_WIDTH-1:0]  mem_d [NUM_ENTRIES-1:1];
    logic [DATA_WIDTH-1:0]  entries [NUM_ENTRIES];

    seq_mem_rf_wr_decoder #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_wr_decoder (
        .write_en_i   (write_en),
        .write_addr_i (write_addr),
        .entry_we_o   (entry_we)
    );

    // Reset wins over any write presented in the same cycle.
    always_comb begin
        for (int i = 1; i < NUM_ENTRIES; i++) begin
            mem_d[i] = mem_q[i];
            if (reset) begin
                mem_d[i] = '0;
            end else if (entry_we[i]) begin
                mem_d[i] = write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < NUM_ENTRIES; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Entry 0 has no flop; it is a constant zero in the read view.
    always_comb begin
        entries[0] = '0;
        for (int i = 1; i < NUM_ENTRIES; i++) begin
            entries[i] = mem_q[i];
        end
    end

    always_comb begin
        read_data = entries[read_addr];
`ifdef SEQ_MEM_RF_BYPASS_EN
        if (write_en && (write_addr == read_addr) && (read_addr != '0)) begin
            read_data = write_data;
        end
`endif
    end

endmodule

// File: tb/tb_seq_mem_8x8b_1r1w_rf_z.sv
// Self-checking bench: directed steps plus random traffic against an array-based register model.
module tb_seq_mem_8x8b_1r1w_rf_z;
    import seq_mem_rf_pkg::*;

    logic     clk;
    logic     reset;
    rf_addr_t read_addr;
    rf_data_t read_data;
    logic     write_en;
    rf_addr_t write_addr;
    rf_data_t write_data;

    int tests;
    int fails;

    logic [7:0] mdl [8];

    seq_mem_8x8b_1r1w_rf_z dut (
        .clk        (clk),
        .reset      (reset),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_read(input logic [2:0] ra, input logic we,
                                            input logic [2:0] wa, input logic [7:0] wd);
        if (ra == 3'd0) return 8'h00;
`ifdef SEQ_MEM_RF_BYPASS_EN
        if (we && wa == ra) return wd;
`endif
        return mdl[ra];
    endfunction

    // Drive one cycle, optionally check the combinational read before the edge, then
    // advance the model past the edge.
    task automatic step(input logic rst, input logic [2:0] ra, input logic we,
                        input logic [2:0] wa, input logic [7:0] wd, input logic chk,
                        input string tag);
        logic [7:0] expv;
        reset      = rst;
        read_addr  = ra;
        write_en   = we;
        write_addr = wa;
        write_data = wd;
        #1;
        if (chk) begin
            expv = exp_read(ra, we, wa, wd);
            tests++;
            assert (read_data === expv) else begin
                fails++;
                $error("FAIL %s: ra=%0d read_data=%h expected %h", tag, ra, read_data, expv);
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        end else if (we && wa != 3'd0) begin
            mdl[wa] = wd;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat [7];
        tests = 0;
        fails = 0;
        for (int i = 0; i < 8; i++) mdl[i] = 8'hxx;
        pat = '{8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

        step(1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, "reset");
        for (int a = 0; a < 8; a++) step(1'b0, 3'(a), 1'b0, 3'd0, 8'h00, 1'b1, "post_reset");

        // Same-cycle collision returns the old value.
        step(1'b0, 3'd1, 1'b1, 3'd1, 8'hAB, 1'b1, "collide_old");
        tests++;
        assert (mdl[1] === 8'hAB) else begin
            fails++;
            $error("FAIL model_wr: mdl=%h expected %h", mdl[1], 8'hAB);
        end
        step(1'b0, 3'd1, 1'b0, 3'd0, 8'h00, 1'b1, "read_after_wr");
        step(1'b0, 3'd2, 1'b1, 3'd2, 8'hCD, 1'b1, "wr2_first");
        step(1'b0, 3'd2, 1'b1, 3'd2, 8'hEF, 1'b1, "wr2_second");
        step(1'b0, 3'd2, 1'b0, 3'd0, 8'h00, 1'b1, "rd2_final");

        for (int a = 1; a < 8; a++) step(1'b0, 3'd0, 1'b1, 3'(a), pat[a-1], 1'b1, "fill");
        for (int a = 1; a < 8; a++) step(1'b0, 3'(a), 1'b1, 3'd0, 8'hFF, 1'b1, "rd_wr0");

        for (int k = 0; k < 8; k++) begin
            step(1'b0, 3'd0, 1'b1, 3'd0, 8'(8'h01 + 8'(k * 8'h22)), 1'b1, "zero_wr");
            step(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, "zero_idle");
        end

        for (int a = 1; a < 8; a++) step(1'b0, 3'd0, 1'b1, 3'(a), 8'h00, 1'b0, "rf_init");
        for (int n = 0; n < 40; n++) begin
            step(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'b1, "random");
        end
        for (int a = 0; a < 8; a++) step(1'b0, 3'(a), 1'b0, 3'd0, 8'h00, 1'b1, "random_sweep");

        step(1'b0, 3'd3, 1'b1, 3'd3, 8'h5A, 1'b1, "pre_reset_wr");
        step(1'b0, 3'd3, 1'b0, 3'd0, 8'h00, 1'b1, "pre_reset_rd");
        step(1'b1, 3'd0, 1'b1, 3'd4, 8'h77, 1'b0, "mid_reset");
        step(1'b0, 3'd3, 1'b0, 3'd0, 8'h00, 1'b1, "reset_clr3");
        step(1'b0, 3'd4, 1'b0, 3'd0, 8'h00, 1'b1, "reset_drop4");

        // Expectation depends on the build: forwarded with bypass, old value without.
        step(1'b0, 3'd5, 1'b1, 3'd5, 8'h3C, 1'b1, "bypass_5");
        step(1'b0, 3'd0, 1'b1, 3'd0, 8'h3C, 1'b1, "bypass_0");
        step(1'b0, 3'd5, 1'b0, 3'd0, 8'h00, 1'b1, "bypass_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_mem_8x8b_1r1w_rf_z.md
Name: seq_mem_8x8b_1r1w_rf_z

Overview:
- Small register file: 8 entries × 8 bits, one combinational read port and one synchronous write port.
- Entry 0 is hardwired to zero: reads of address 0 always return 0, and writes to address 0 are discarded.
- Used as a scalar register file inside datapath blocks (RISC-style x0 semantics).

Parameters:
- NUM_ENTRIES, 8, number of registers; must be a power of 2, ≥2.
- DATA_WIDTH, 8, bits per register.
- ADDR_WIDTH, $clog2(NUM_ENTRIES) = 3, address width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- read_addr  input  ADDR_WIDTH  read port address.
- read_data  output  DATA_WIDTH  read port data, combinational.
- write_en  input  1  write enable.
- write_addr  input  ADDR_WIDTH  write port address.
- write_data  input  DATA_WIDTH  write port data.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Storage: entries 1..NUM_ENTRIES-1 are flops. Entry 0 has no storage.
- Reset:
  - On a rising edge with reset=1, all entries 1..7 are cleared to 0x00.
  - Reset has priority over write; a write presented in a reset cycle is dropped.
  - Because read_data is combinational, it shows 0x00 for every address from the cycle after reset.
- Write:
  - On a rising edge with reset=0 and write_en=1, write_data is stored into entry write_addr.
  - If write_addr==0, the write is ignored and no state changes.
  - write_en=0 leaves all state unchanged; write_addr and write_data are don't-care.
- Read:
  - read_data = 0 when read_addr==0, otherwise the current contents of entry read_addr.
  - Purely combinational; zero-cycle latency from read_addr to read_data.
- Same-cycle read/write to the same address (default build): read_data returns the OLD value. The new value is visible from the cycle after the edge.
  - Example: entry 1 = 0x00, drive ra=1, we=1, wa=1, wd=0xAB → read_data=0x00 this cycle, 0xAB next cycle.
- No X propagation: all outputs are defined after the first reset.
- Reset asserted mid-sequence clears all contents on that edge, regardless of pending writes.

Optional Feature:
- Macro: SEQ_MEM_RF_BYPASS_EN.
- Defined: write-to-read bypass. When write_en=1, write_addr==read_addr and read_addr!=0, read_data = write_data combinationally in the same cycle. Address 0 still reads 0.
- Not defined (default): no bypass; behaviour as in Behaviour.

Decomposition:
- Shared package seq_mem_rf_pkg holds:
  - localparams for default NUM_ENTRIES and DATA_WIDTH, and the derived ADDR_WIDTH;
  - typedefs rf_addr_t (logic [ADDR_WIDTH-1:0]) and rf_data_t (logic [DATA_WIDTH-1:0]).
- One natural sub-module: seq_mem_rf_wr_decoder. It turns write_en/write_addr into a one-hot per-entry write-enable vector, with bit 0 forced to 0.
- Read mux and storage live in the top module.

Test Plan:
- Reset then read all addresses 0..7 → read_data=0x00 for each.
- Write 0xAB to addr 1 while reading addr 1 → 0x00 in that cycle. Then read addr 1 with we=0 → 0xAB. Write 0xCD then 0xEF to addr 2 → reading addr 2 gives 0xCD after the first write and 0xEF after the second.
- Write 0x23, 0x45, 0x67, 0x89, 0xAB, 0xCD, 0xEF to addrs 1..7 on consecutive cycles. Then read addrs 1..7 while writing 0xFF to addr 0 every cycle → the read values return exactly in order, unaffected by the addr-0 writes.
- Alternate writes of 0x01, 0x23, …, 0xEF to addr 0 with idle cycles, reading addr 0 throughout → read_data=0x00 every cycle.
- 40 cycles of random ra/we/wa/wd after rf_init (write 0 to 1..7) → matches a golden model with old-value-on-collision and zero-register semantics.
- Write 0x5A to addr 3, then assert reset for one cycle while presenting a write of 0x77 to addr 4 → both addr 3 and addr 4 read 0x00 afterwards.
- With SEQ_MEM_RF_BYPASS_EN defined: ra=wa=5, we=1, wd=0x3C → read_data=0x3C in the same cycle; ra=wa=0 → read_data=0x00.
